// File: rtl/emu_sdram_responder.sv
// Two-channel ROM read responder (object ROM and main CPU) sharing one SDRAM read port.
// Define EMU_SDRAM_WORDCACHE_EN to add a one-word cache per channel.
module emu_sdram_responder #(
  parameter logic [21:0] MAINCPU_BASE = 22'h000000,
  parameter logic [21:0] OBJROM_BASE  = 22'h020000
) (
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_INITRST_n,
  input  logic [16:0] i_EMU_MAINCPU_ADDR,
  output logic [7:0]  o_EMU_MAINCPU_DATA,
  input  logic        i_EMU_MAINCPU_RQ_n,
  output logic        o_EMU_MAINCPU_OK,
  input  logic [16:0] i_EMU_OBJROM_ADDR,
  output logic [7:0]  o_EMU_OBJROM_DATA,
  input  logic        i_EMU_OBJROM_RQ_n,
  output logic        o_EMU_OBJROM_OK,
  output logic        o_SDRAM_RD,
  output logic [21:0] o_SDRAM_ADDR,
  input  logic        i_SDRAM_ACK,
  input  logic [15:0] i_SDRAM_DQ
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic        owner_obj;
  logic [16:0] lat_addr;
  logic [16:0] main_srv_addr, obj_srv_addr;
  logic        main_srv_vld, obj_srv_vld;
  logic        main_rq_prev, obj_rq_prev;

  logic main_fall, obj_fall, main_pend, obj_pend;
  logic [7:0] ack_byte;

  function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

  assign main_fall = main_rq_prev & ~i_EMU_MAINCPU_RQ_n;
  assign obj_fall  = obj_rq_prev & ~i_EMU_OBJROM_RQ_n;
  assign main_pend = ~i_EMU_MAINCPU_RQ_n & (~main_srv_vld | (i_EMU_MAINCPU_ADDR != main_srv_addr));
  assign obj_pend  = ~i_EMU_OBJROM_RQ_n & (~obj_srv_vld | (i_EMU_OBJROM_ADDR != obj_srv_addr));
  assign ack_byte  = sel_byte(i_SDRAM_DQ, lat_addr[0]);

  assign o_EMU_MAINCPU_OK = ~i_EMU_MAINCPU_RQ_n & main_srv_vld & (i_EMU_MAINCPU_ADDR == main_srv_addr);
  assign o_EMU_OBJROM_OK  = ~i_EMU_OBJROM_RQ_n & obj_srv_vld & (i_EMU_OBJROM_ADDR == obj_srv_addr);

`ifdef EMU_SDRAM_WORDCACHE_EN
  logic [15:0] main_cword, obj_cword;
  logic [15:0] main_ctag, obj_ctag;
  logic        main_cvld, obj_cvld;
  logic        main_hit, obj_hit;

  assign main_hit = main_cvld & (main_ctag == i_EMU_MAINCPU_ADDR[16:1]);
  assign obj_hit  = obj_cvld & (obj_ctag == i_EMU_OBJROM_ADDR[16:1]);
`endif

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      state              <= IDLE;
      owner_obj          <= 1'b0;
      lat_addr           <= '0;
      o_SDRAM_RD         <= 1'b0;
      o_SDRAM_ADDR       <= '0;
      o_EMU_MAINCPU_DATA <= 8'h00;
      o_EMU_OBJROM_DATA  <= 8'h00;
      main_srv_addr      <= '0;
      obj_srv_addr       <= '0;
      main_srv_vld       <= 1'b0;
      obj_srv_vld        <= 1'b0;
      main_rq_prev       <= 1'b1;
      obj_rq_prev        <= 1'b1;
`ifdef EMU_SDRAM_WORDCACHE_EN
      main_cword         <= '0;
      obj_cword          <= '0;
      main_ctag          <= '0;
      obj_ctag           <= '0;
      main_cvld          <= 1'b0;
      obj_cvld           <= 1'b0;
`endif
    end else begin
      main_rq_prev <= i_EMU_MAINCPU_RQ_n;
      obj_rq_prev  <= i_EMU_OBJROM_RQ_n;
      case (state)
        IDLE: begin
`ifdef EMU_SDRAM_WORDCACHE_EN
          if (obj_pend && obj_hit) begin
            o_EMU_OBJROM_DATA <= sel_byte(obj_cword, i_EMU_OBJROM_ADDR[0]);
            obj_srv_addr      <= i_EMU_OBJROM_ADDR;
            obj_srv_vld       <= 1'b1;
          end else if (obj_pend) begin
`else
          if (obj_pend) begin
`endif
            state        <= BUSY;
            o_SDRAM_RD   <= 1'b1;
            owner_obj    <= 1'b1;
            lat_addr     <= i_EMU_OBJROM_ADDR;
            o_SDRAM_ADDR <= OBJROM_BASE + {5'b0, i_EMU_OBJROM_ADDR};
`ifdef EMU_SDRAM_WORDCACHE_EN
          end else if (main_pend && main_hit) begin
            o_EMU_MAINCPU_DATA <= sel_byte(main_cword, i_EMU_MAINCPU_ADDR[0]);
            main_srv_addr      <= i_EMU_MAINCPU_ADDR;
            main_srv_vld       <= 1'b1;
`endif
          end else if (main_pend) begin
            state        <= BUSY;
            o_SDRAM_RD   <= 1'b1;
            owner_obj    <= 1'b0;
            lat_addr     <= i_EMU_MAINCPU_ADDR;
            o_SDRAM_ADDR <= MAINCPU_BASE + {5'b0, i_EMU_MAINCPU_ADDR};
          end
        end
        BUSY: begin
          if (i_SDRAM_ACK) begin
            state      <= IDLE;
            o_SDRAM_RD <= 1'b0;
            if (owner_obj) begin
              o_EMU_OBJROM_DATA <= ack_byte;
              obj_srv_addr      <= lat_addr;
              obj_srv_vld       <= 1'b1;
`ifdef EMU_SDRAM_WORDCACHE_EN
              obj_cword         <= i_SDRAM_DQ;
              obj_ctag          <= lat_addr[16:1];
              obj_cvld          <= 1'b1;
`endif
            end else begin
              o_EMU_MAINCPU_DATA <= ack_byte;
              main_srv_addr      <= lat_addr;
              main_srv_vld       <= 1'b1;
`ifdef EMU_SDRAM_WORDCACHE_EN
              main_cword         <= i_SDRAM_DQ;
              main_ctag          <= lat_addr[16:1];
              main_cvld          <= 1'b1;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
      // A fresh request edge wins over a same-cycle completion so the channel always refetches.
      if (main_fall) begin
        main_srv_vld <= 1'b0;
`ifdef EMU_SDRAM_WORDCACHE_EN
        main_cvld    <= 1'b0;
`endif
      end
      if (obj_fall) begin
        obj_srv_vld <= 1'b0;
`ifdef EMU_SDRAM_WORDCACHE_EN
        obj_cvld    <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_emu_sdram_responder.sv
// Directed self-checking bench for emu_sdram_responder with hand-computed expectations.
module tb_emu_sdram_responder;

  logic        clk;
  logic        rst_n;
  logic [16:0] main_addr;
  logic [7:0]  main_data;
  logic        main_rq_n;
  logic        main_ok;
  logic [16:0] obj_addr;
  logic [7:0]  obj_data;
  logic        obj_rq_n;
  logic        obj_ok;
  logic        sdram_rd;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic [15:0] sdram_dq;

  int checkCount = 0;
  int errorCount = 0;

  emu_sdram_responder dut (
    .i_EMU_MCLK         (clk),
    .i_EMU_INITRST_n    (rst_n),
    .i_EMU_MAINCPU_ADDR (main_addr),
    .o_EMU_MAINCPU_DATA (main_data),
    .i_EMU_MAINCPU_RQ_n (main_rq_n),
    .o_EMU_MAINCPU_OK   (main_ok),
    .i_EMU_OBJROM_ADDR  (obj_addr),
    .o_EMU_OBJROM_DATA  (obj_data),
    .i_EMU_OBJROM_RQ_n  (obj_rq_n),
    .o_EMU_OBJROM_OK    (obj_ok),
    .o_SDRAM_RD         (sdram_rd),
    .o_SDRAM_ADDR       (sdram_addr),
    .i_SDRAM_ACK        (sdram_ack),
    .i_SDRAM_DQ         (sdram_dq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a read request, delays lag cycles, then returns the word with a one-cycle ACK.
  task automatic applyStimulus(input string tag, input int lag, input logic [15:0] word);
    int n = 0;
    while (!sdram_rd && n < 20) begin
      step(1);
      n++;
    end
    checkOutput(tag, sdram_rd, 1'b1);
    repeat (lag) step(1);
    sdram_dq  = word;
    sdram_ack = 1'b1;
    step(1);
    sdram_ack = 1'b0;
    sdram_dq  = 16'h0000;
  endtask

  initial begin
    rst_n     = 1'b0;
    main_addr = 17'h0;
    main_rq_n = 1'b0;
    obj_addr  = 17'h0;
    obj_rq_n  = 1'b1;
    sdram_ack = 1'b0;
    sdram_dq  = 16'h0;
    #3;
    checkOutput("rst_rd", sdram_rd, 1'b0);
    checkOutput("rst_addr", sdram_addr, 22'h0);
    checkOutput("rst_main_data", main_data, 8'h00);
    checkOutput("rst_obj_data", obj_data, 8'h00);
    checkOutput("rst_main_ok", main_ok, 1'b0);
    main_rq_n = 1'b1;
    #4;
    rst_n = 1'b1;
    step(1);

    $display("[TB] basic main CPU fetch");
    main_addr = 17'h00010;
    main_rq_n = 1'b0;
    step(1);
    checkOutput("t1_rd", sdram_rd, 1'b1);
    checkOutput("t1_addr", sdram_addr, 22'h000010);
    checkOutput("t1_ok_busy", main_ok, 1'b0);
    applyStimulus("t1_wait", 1, 16'hA55A);
    checkOutput("t1_rd_drop", sdram_rd, 1'b0);
    checkOutput("t1_data", main_data, 8'h5A);
    checkOutput("t1_ok", main_ok, 1'b1);
    step(2);
    checkOutput("t1_hold_data", main_data, 8'h5A);
    checkOutput("t1_hold_rd", sdram_rd, 1'b0);

    $display("[TB] priority object ROM over main CPU");
    main_rq_n = 1'b1;
    step(1);
    main_addr = 17'h00040;
    main_rq_n = 1'b0;
    obj_addr  = 17'h00001;
    obj_rq_n  = 1'b0;
    step(1);
    checkOutput("t2_rd", sdram_rd, 1'b1);
    checkOutput("t2_addr", sdram_addr, 22'h020001);
    applyStimulus("t2_wait_obj", 0, 16'hBEEF);
    checkOutput("t2_obj_data", obj_data, 8'hBE);
    checkOutput("t2_obj_ok", obj_ok, 1'b1);
    checkOutput("t2_main_ok", main_ok, 1'b0);
    step(1);
    checkOutput("t2_main_rd", sdram_rd, 1'b1);
    checkOutput("t2_main_addr", sdram_addr, 22'h000040);
    applyStimulus("t2_wait_main", 0, 16'h1234);
    checkOutput("t2_main_data", main_data, 8'h34);
    checkOutput("t2_main_ok2", main_ok, 1'b1);
    checkOutput("t2_obj_ok2", obj_ok, 1'b1);

    $display("[TB] object ROM top address");
    obj_addr = 17'h1FFFF;
    step(1);
    checkOutput("t5_addr", sdram_addr, 22'h03FFFF);
    applyStimulus("t5_wait", 0, 16'h9A00);
    checkOutput("t5_obj_data", obj_data, 8'h9A);
    obj_rq_n = 1'b1;

    $display("[TB] address change during fetch");
    main_addr = 17'h00010;
    step(1);
    checkOutput("t3_addr1", sdram_addr, 22'h000010);
    main_addr = 17'h00020;
    #1;
    checkOutput("t3_ok_busy", main_ok, 1'b0);
    applyStimulus("t3_wait1", 1, 16'h7788);
    checkOutput("t3_data_old", main_data, 8'h88);
    checkOutput("t3_ok_stale", main_ok, 1'b0);
    step(1);
    checkOutput("t3_rd2", sdram_rd, 1'b1);
    checkOutput("t3_addr2", sdram_addr, 22'h000020);
    applyStimulus("t3_wait2", 0, 16'h0102);
    checkOutput("t3_data_new", main_data, 8'h02);
    checkOutput("t3_ok_new", main_ok, 1'b1);
    main_addr = 17'h00010;
    #1;
    checkOutput("t3_ok_back", main_ok, 1'b0);

    $display("[TB] reset in the middle of a fetch");
    step(1);
    checkOutput("t4_rd_busy", sdram_rd, 1'b1);
    rst_n     = 1'b0;
    main_rq_n = 1'b1;
    #1;
    checkOutput("t4_rd_drop", sdram_rd, 1'b0);
    checkOutput("t4_data", main_data, 8'h00);
    #2;
    rst_n = 1'b1;
    step(1);
    sdram_dq  = 16'hFFFF;
    sdram_ack = 1'b1;
    step(1);
    sdram_ack = 1'b0;
    checkOutput("t4_ack_rd", sdram_rd, 1'b0);
    checkOutput("t4_ack_main_data", main_data, 8'h00);
    checkOutput("t4_ack_obj_data", obj_data, 8'h00);
    main_addr = 17'h00000;
    main_rq_n = 1'b0;
    #1;
    checkOutput("t4_ok", main_ok, 1'b0);

    $display("[TB] request withdrawn during fetch, then re-raised");
    step(1);
    checkOutput("t6_rd", sdram_rd, 1'b1);
    checkOutput("t6_addr", sdram_addr, 22'h000000);
    main_rq_n = 1'b1;
    applyStimulus("t6_wait", 0, 16'hCAFE);
    checkOutput("t6_data", main_data, 8'hFE);
    main_rq_n = 1'b0;
    step(1);
    checkOutput("t6_refetch_ok", main_ok, 1'b0);
    step(1);
    checkOutput("t6_refetch_rd", sdram_rd, 1'b1);
    applyStimulus("t6_wait2", 0, 16'hAB01);
    checkOutput("t6_data2", main_data, 8'h01);
    checkOutput("t6_ok2", main_ok, 1'b1);

    $display("[TB] odd byte of the word just fetched");
    main_addr = 17'h00001;
    step(1);
`ifdef EMU_SDRAM_WORDCACHE_EN
    checkOutput("t7_no_rd", sdram_rd, 1'b0);
    checkOutput("t7_ok", main_ok, 1'b1);
    checkOutput("t7_data", main_data, 8'hAB);
`else
    checkOutput("t7_rd", sdram_rd, 1'b1);
    checkOutput("t7_addr", sdram_addr, 22'h000001);
    applyStimulus("t7_wait", 0, 16'h5566);
    checkOutput("t7_data", main_data, 8'h55);
    checkOutput("t7_ok", main_ok, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/emu_sdram_responder.md
EMU_SDRAM_RESPONDER -- requirements
Module: emu_sdram_responder

Interface
REQ-001 SHALL have parameter MAINCPU_BASE, default 22'h000000, SDRAM byte base of main CPU ROM region.
REQ-002 SHALL have parameter OBJROM_BASE, default 22'h020000, SDRAM byte base of object ROM region.
REQ-003 SHALL have ports (clock and reset first):
- i_EMU_MCLK  in  1  sole clock.
- i_EMU_INITRST_n  in  1  asynchronous active-low reset.
- i_EMU_MAINCPU_ADDR  in  17  main CPU byte address.
- o_EMU_MAINCPU_DATA  out  8  main CPU read byte.
- i_EMU_MAINCPU_RQ_n  in  1  main CPU request, active low, level.
- o_EMU_MAINCPU_OK  out  1  data valid for current main CPU address.
- i_EMU_OBJROM_ADDR  in  17  object ROM byte address.
- o_EMU_OBJROM_DATA  out  8  object ROM read byte.
- i_EMU_OBJROM_RQ_n  in  1  object ROM request, active low, level.
- o_EMU_OBJROM_OK  out  1  data valid for current object ROM address.
- o_SDRAM_RD  out  1  read request to SDRAM controller, level.
- o_SDRAM_ADDR  out  22  SDRAM byte address.
- i_SDRAM_ACK  in  1  one-cycle strobe; i_SDRAM_DQ valid.
- i_SDRAM_DQ  in  16  SDRAM read word.

Function
REQ-004 Per channel SHALL hold served address register (17 b) and served-valid flag.
REQ-005 Channel pending SHALL be: RQ_n low AND (served-valid clear OR ADDR != served address).
REQ-006 Falling edge of RQ_n (registered previous sample high, current low) SHALL clear that channel's served-valid, forcing refetch.
REQ-007 FSM states SHALL be IDLE, BUSY; reset state IDLE.
REQ-008 IDLE: if OBJROM pending, latch OBJROM as owner, else if MAINCPU pending, latch MAINCPU; on latch go BUSY next cycle with o_SDRAM_RD=1.
REQ-009 Fixed priority SHALL be OBJROM over MAINCPU on simultaneous pending.
REQ-010 o_SDRAM_ADDR SHALL equal owner base + zero-extended latched ADDR, modulo 2^22, registered at latch, stable throughout BUSY.
REQ-011 BUSY: o_SDRAM_RD held 1 until i_SDRAM_ACK; ACK cycle latches byte, sets served address=latched ADDR, served-valid=1, o_SDRAM_RD=0 next cycle, returns IDLE.
REQ-012 Byte select: latched ADDR[0]=0 -> i_SDRAM_DQ[7:0], ADDR[0]=1 -> i_SDRAM_DQ[15:8].
REQ-013 i_SDRAM_ACK in IDLE SHALL be ignored.
REQ-014 Address change during BUSY SHALL NOT abort; completed fetch stores old address, channel re-pends immediately after.
REQ-015 o_*_OK SHALL be combinational: RQ_n low AND served-valid AND ADDR == served address.
REQ-016 o_*_DATA SHALL hold last fetched byte until next completed fetch for that channel.
REQ-017 Minimum latency pending->OK SHALL be 3 cycles with ACK on first BUSY cycle (latch, BUSY/ACK, register update).
REQ-018 RQ_n deasserted during BUSY SHALL still complete and store fetch.

Reset
REQ-019 Reset SHALL force: IDLE, o_SDRAM_RD=0, o_SDRAM_ADDR=0, both DATA=8'h00, served-valid=0, served addresses=0, edge registers=1.
REQ-020 Reset asserted mid-BUSY SHALL drop o_SDRAM_RD immediately; a later ACK in IDLE is ignored.

Configuration
REQ-021 Macro EMU_SDRAM_WORDCACHE_EN defined: each channel SHALL keep one 16-bit word cache tagged by ADDR[16:1] plus valid; pending with tag hit SHALL load byte from cache in 1 cycle (OK next cycle) without SDRAM access; every fetch refills cache; reset and RQ_n falling edge invalidate it.
REQ-022 Macro undefined: no cache logic; every pending request goes to SDRAM.

Verification
REQ-023 MAINCPU RQ_n=0, ADDR=17'h00010, DQ=16'hA55A, ACK 2 cycles after RD -> o_SDRAM_ADDR=22'h000010, DATA=8'h5A, OK=1.
REQ-024 Both pending same cycle, OBJROM ADDR=17'h00001 -> first RD at 22'h020001, DATA=DQ[15:8]; MAINCPU serviced next.
REQ-025 MAINCPU ADDR changes 0x10->0x20 mid-BUSY -> fetch stores 0x10, OK=0, second RD at 0x20 follows.
REQ-026 Reset pulse during BUSY, then ACK -> RD=0, DATA=8'h00, OK=0, no state change from ACK.
REQ-027 With EMU_SDRAM_WORDCACHE_EN: fetch 0x10 then ADDR=0x11 -> no RD, OK after 1 cycle, DATA=DQ[15:8] of cached word.
